// File: rtl/johnson_pkg.sv
// Shared types and helpers for decoding an N-bit Johnson (twisted-ring) code.
// The helpers take the code zero-extended to JC_MAX_N bits plus the real width n,
// so one package serves any instance width up to JC_MAX_N.
package johnson_pkg;

  localparam int JC_MAX_N     = 32;
  localparam int JC_IDX_W     = 7;                       // holds indices up to 2*JC_MAX_N-1
  localparam int JC_N_DEFAULT = 4;
  localparam int JC_PH_W      = $clog2(2 * JC_N_DEFAULT);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } jc_state_e;

  // A Johnson code has at most one bit change between adjacent bits 0..n-1.
  function automatic logic jc_is_legal(input logic [JC_MAX_N-1:0] c, input int n);
    int changes;
    changes = 0;
    for (int i = 0; i < JC_MAX_N - 1; i++) begin
      if ((i < n - 1) && (c[i] != c[i+1])) changes++;
    end
    return (changes <= 1);
  endfunction

  // Next code of the counter: shift left, feed back the inverted MSB.
  function automatic logic [JC_MAX_N-1:0] jc_succ(input logic [JC_MAX_N-1:0] c, input int n);
    logic [JC_MAX_N-1:0] s;
    s = '0;
    for (int i = 1; i < JC_MAX_N; i++) begin
      if (i < n) s[i] = c[i-1];
    end
    s[0] = ~c[n-1];
    return s;
  endfunction

  // Phase index of a legal code. Codes with bit 0 set are the filling half
  // (index = number of ones); the rest are the emptying half (2n - ones), with
  // all-zero mapping to phase 0.
  function automatic logic [JC_IDX_W-1:0] jc_to_idx(input logic [JC_MAX_N-1:0] c, input int n);
    int ones;
    ones = 0;
    for (int i = 0; i < JC_MAX_N; i++) begin
      if ((i < n) && c[i]) ones++;
    end
    if (c[0])          return JC_IDX_W'(ones);
    else if (ones == 0) return '0;
    else               return JC_IDX_W'(2 * n - ones);
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational decode of one Johnson code: legality, binary phase and one-hot
// phase. Illegal codes produce zero index and an all-zero one-hot vector.
module johnson_code_decode #(
  parameter int N    = 4,
  parameter int PH_W = $clog2(2 * N)
) (
  input  logic [N-1:0]    code,
  output logic            legal,
  output logic [PH_W-1:0] idx,
  output logic [2*N-1:0]  onehot
);
  import johnson_pkg::*;

  logic [PH_W-1:0] raw_idx;

  assign legal   = jc_is_legal(JC_MAX_N'(code), N);
  assign raw_idx = PH_W'(jc_to_idx(JC_MAX_N'(code), N));
  assign idx     = legal ? raw_idx : '0;
  assign onehot  = legal ? ({{(2*N-1){1'b0}}, 1'b1} << raw_idx) : '0;

endmodule

// File: rtl/johnson_phase_decoder.sv
// Registers the upstream Johnson counter code, decodes it to one-hot and binary
// phase, and checks every advance against the legal successor. A SEARCH/LOCKED
// FSM tracks sequence lock; revolutions and sequence errors are counted.
module johnson_phase_decoder #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int REV_W    = 8,
  parameter int ERR_W    = 8,
  localparam int PH_W    = $clog2(2 * N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     jc_in,
  input  logic             jc_valid,
  output logic [2*N-1:0]   phase_onehot,
  output logic [PH_W-1:0]  phase_idx,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [REV_W-1:0] rev_count,
  output logic [ERR_W-1:0] err_count
);
  import johnson_pkg::*;

  localparam int RUN_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  // Error counter sticks at all-ones rather than wrapping.
  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---- stage p0: combinational view of the incoming sample ----
  logic            legal_p0;
  logic [PH_W-1:0] idx_p0;
  logic [2*N-1:0]  onehot_p0;
  logic [N-1:0]    succ_p0;
  logic            good_p0;
  logic            wrap_p0;

  // ---- stage p1: registered state ----
  jc_state_e       state_p1, state_d;
  logic [RUN_W-1:0] run_p1, run_d;
  logic [N-1:0]    prev_p1, prev_d;
  logic [PH_W-1:0] prev_idx_p1, prev_idx_d;
  logic            has_prev_p1, has_prev_d;
  logic [2*N-1:0]  onehot_p1, onehot_d;
  logic [PH_W-1:0] idx_p1, idx_d;
  logic            illegal_p1, illegal_d;
  logic            seq_err_p1, seq_err_d;
  logic [REV_W-1:0] rev_p1, rev_d;
  logic [ERR_W-1:0] err_p1, err_d;

  johnson_code_decode #(
    .N    (N),
    .PH_W (PH_W)
  ) u_decode (
    .code   (jc_in),
    .legal  (legal_p0),
    .idx    (idx_p0),
    .onehot (onehot_p0)
  );

  assign succ_p0 = N'(jc_succ(JC_MAX_N'(prev_p1), N));
  assign good_p0 = jc_valid && has_prev_p1 && legal_p0 && (jc_in == succ_p0);
  assign wrap_p0 = good_p0 && (prev_idx_p1 == PH_W'(2 * N - 1)) && (idx_p0 == '0);

  // FSM state and successor-run register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p1 <= SEARCH;
      run_p1   <= '0;
    end else begin
      state_p1 <= state_d;
      run_p1   <= run_d;
    end
  end

  // Next-state: count good transitions in SEARCH, drop lock on any bad sample
  always_comb begin
    state_d = state_p1;
    run_d   = run_p1;
    if (jc_valid) begin
      case (state_p1)
        SEARCH: begin
          if (good_p0) begin
            if (run_p1 == RUN_W'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_p1 + 1'b1;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (!good_p0) begin
            state_d = SEARCH;
            run_d   = '0;
          end
        end
        default: begin
          state_d = SEARCH;
          run_d   = '0;
        end
      endcase
    end
  end

  // Output/next-data decode: phase, pulses, previous code and counters
  always_comb begin
    onehot_d   = onehot_p1;
    idx_d      = idx_p1;
    illegal_d  = 1'b0;
    seq_err_d  = 1'b0;
    rev_d      = rev_p1;
    err_d      = err_p1;
    prev_d     = prev_p1;
    prev_idx_d = prev_idx_p1;
    has_prev_d = has_prev_p1;
    if (jc_valid) begin
      if (legal_p0) begin
        onehot_d   = onehot_p0;
        idx_d      = idx_p0;
        prev_d     = jc_in;
        prev_idx_d = idx_p0;
        has_prev_d = 1'b1;
      end else begin
        onehot_d   = '0;
        illegal_d  = 1'b1;
        has_prev_d = 1'b0;
      end
      if (state_p1 == LOCKED) begin
        if (!good_p0) begin
          seq_err_d = 1'b1;
          err_d     = sat_inc_err(err_p1);
        end else if (wrap_p0) begin
          rev_d = rev_p1 + 1'b1;
        end
      end
    end
  end

  // Control and output registers; all visible outputs clear on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      has_prev_p1 <= 1'b0;
      onehot_p1   <= '0;
      idx_p1      <= '0;
      illegal_p1  <= 1'b0;
      seq_err_p1  <= 1'b0;
      rev_p1      <= '0;
      err_p1      <= '0;
    end else begin
      has_prev_p1 <= has_prev_d;
      onehot_p1   <= onehot_d;
      idx_p1      <= idx_d;
      illegal_p1  <= illegal_d;
      seq_err_p1  <= seq_err_d;
      rev_p1      <= rev_d;
      err_p1      <= err_d;
    end
  end

  // Previous-code data; only meaningful while has_prev is set
  always_ff @(posedge clock) begin
    prev_p1     <= prev_d;
    prev_idx_p1 <= prev_idx_d;
  end

  assign phase_onehot = onehot_p1;
  assign phase_idx    = idx_p1;
  assign illegal      = illegal_p1;
  assign seq_err      = seq_err_p1;
  assign locked       = (state_p1 == LOCKED);
  assign rev_count    = rev_p1;
  assign err_count    = err_p1;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder: a default instance plus an
// ERR_W=2 instance sharing the same stimulus for the saturation case.
module tb_johnson_phase_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] jc_in = 4'b0000;
  logic       jc_valid = 1'b0;

  logic [7:0] phase_onehot;
  logic [2:0] phase_idx;
  logic       illegal, seq_err, locked;
  logic [7:0] rev_count, err_count;

  logic [7:0] e2_onehot;
  logic [2:0] e2_idx;
  logic       e2_illegal, e2_seq_err, e2_locked;
  logic [7:0] e2_rev;
  logic [1:0] e2_err;

  int checks = 0;
  int failures = 0;

  logic [3:0] seq [0:7] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

  always #5 clock = ~clock;

  johnson_phase_decoder #(.N(4), .LOCK_CNT(3), .REV_W(8), .ERR_W(8)) dut (
    .clock(clock), .reset(reset), .jc_in(jc_in), .jc_valid(jc_valid),
    .phase_onehot(phase_onehot), .phase_idx(phase_idx), .illegal(illegal),
    .seq_err(seq_err), .locked(locked), .rev_count(rev_count), .err_count(err_count)
  );

  johnson_phase_decoder #(.N(4), .LOCK_CNT(3), .REV_W(8), .ERR_W(2)) dut_e2 (
    .clock(clock), .reset(reset), .jc_in(jc_in), .jc_valid(jc_valid),
    .phase_onehot(e2_onehot), .phase_idx(e2_idx), .illegal(e2_illegal),
    .seq_err(e2_seq_err), .locked(e2_locked), .rev_count(e2_rev), .err_count(e2_err)
  );

  task automatic step(input logic [3:0] c, input logic v);
    @(negedge clock);
    jc_in    = c;
    jc_valid = v;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    jc_valid = 1'b0;
    jc_in    = 4'b0000;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Reaches LOCKED with phase 0011 on the outputs: 1100,1000,0000,0001 lock, then 0011.
  task automatic goto_locked_0011();
    do_reset();
    step(4'b1100, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0011, 1'b1);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL setup_lock_0011 locked=%b required=1", locked);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (phase_onehot !== 8'h00) begin failures++; $display("FAIL reset_onehot got=%h required=00", phase_onehot); end
    checks++; if (phase_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d required=0", phase_idx); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b required=0", illegal); end
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL reset_seq_err got=%b required=0", seq_err); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b required=0", locked); end
    checks++; if (rev_count !== 8'd0) begin failures++; $display("FAIL reset_rev got=%0d required=0", rev_count); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d required=0", err_count); end
  endtask

  task automatic test_count_lock();
    logic [7:0] exp_oh;
    logic [7:0] exp_rev;
    logic       exp_lock;
    do_reset();
    for (int k = 0; k <= 24; k++) begin
      step(seq[k % 8], 1'b1);
      exp_oh   = 8'b1 << (k % 8);
      exp_lock = (k >= 3);
      exp_rev  = 8'(k / 8);
      checks++; if (phase_idx !== 3'(k % 8)) begin failures++; $display("FAIL count_idx k=%0d got=%0d required=%0d", k, phase_idx, k % 8); end
      checks++; if (phase_onehot !== exp_oh) begin failures++; $display("FAIL count_onehot k=%0d got=%h required=%h", k, phase_onehot, exp_oh); end
      checks++; if (locked !== exp_lock) begin failures++; $display("FAIL count_locked k=%0d got=%b required=%b", k, locked, exp_lock); end
      checks++; if (rev_count !== exp_rev) begin failures++; $display("FAIL count_rev k=%0d got=%0d required=%0d", k, rev_count, exp_rev); end
      checks++; if ({illegal, seq_err} !== 2'b00) begin failures++; $display("FAIL count_pulses k=%0d got=%b%b required=00", k, illegal, seq_err); end
    end
  endtask

  task automatic test_illegal();
    goto_locked_0011();
    step(4'b0101, 1'b1);
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_pulse got=%b required=1", illegal); end
    checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL illegal_seq_err got=%b required=1", seq_err); end
    checks++; if (phase_onehot !== 8'h00) begin failures++; $display("FAIL illegal_onehot got=%h required=00", phase_onehot); end
    checks++; if (phase_idx !== 3'd2) begin failures++; $display("FAIL illegal_idx_hold got=%0d required=2", phase_idx); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL illegal_locked got=%b required=0", locked); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL illegal_err got=%0d required=1", err_count); end
    step(4'b0000, 1'b1);
    checks++; if ({illegal, seq_err, locked} !== 3'b000) begin failures++; $display("FAIL illegal_resume0 got=%b%b%b required=000", illegal, seq_err, locked); end
    checks++; if (phase_onehot !== 8'h01) begin failures++; $display("FAIL illegal_resume_onehot got=%h required=01", phase_onehot); end
    step(4'b0001, 1'b1);
    step(4'b0011, 1'b1);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL illegal_early_relock got=%b required=0", locked); end
    step(4'b0111, 1'b1);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL illegal_relock got=%b required=1", locked); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL illegal_err_after got=%0d required=1", err_count); end
  endtask

  task automatic test_skip();
    goto_locked_0011();
    step(4'b1111, 1'b1);
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL skip_illegal got=%b required=0", illegal); end
    checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL skip_seq_err got=%b required=1", seq_err); end
    checks++; if (phase_idx !== 3'd4) begin failures++; $display("FAIL skip_idx got=%0d required=4", phase_idx); end
    checks++; if (phase_onehot !== 8'h10) begin failures++; $display("FAIL skip_onehot got=%h required=10", phase_onehot); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL skip_locked got=%b required=0", locked); end
    step(4'b1110, 1'b1);
    checks++; if ({seq_err, locked} !== 2'b00) begin failures++; $display("FAIL skip_1110 got=%b%b required=00", seq_err, locked); end
    step(4'b1100, 1'b1);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL skip_1100_locked got=%b required=0", locked); end
    step(4'b1000, 1'b1);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL skip_relock got=%b required=1", locked); end
    checks++; if (phase_idx !== 3'd7) begin failures++; $display("FAIL skip_idx7 got=%0d required=7", phase_idx); end
  endtask

  task automatic test_hold();
    goto_locked_0011();
    for (int k = 0; k < 5; k++) begin
      step(4'b1010, 1'b0);
      checks++; if ({illegal, seq_err} !== 2'b00) begin failures++; $display("FAIL hold_pulses k=%0d got=%b%b required=00", k, illegal, seq_err); end
      checks++; if (phase_idx !== 3'd2) begin failures++; $display("FAIL hold_idx k=%0d got=%0d required=2", k, phase_idx); end
      checks++; if (phase_onehot !== 8'h04) begin failures++; $display("FAIL hold_onehot k=%0d got=%h required=04", k, phase_onehot); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL hold_locked k=%0d got=%b required=1", k, locked); end
      checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL hold_err k=%0d got=%0d required=0", k, err_count); end
    end
    step(4'b0111, 1'b1);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL hold_resume_locked got=%b required=1", locked); end
    checks++; if (phase_idx !== 3'd3) begin failures++; $display("FAIL hold_resume_idx got=%0d required=3", phase_idx); end
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL hold_resume_seq_err got=%b required=0", seq_err); end
  endtask

  task automatic test_repeat();
    goto_locked_0011();
    step(4'b0011, 1'b1);
    checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL repeat_seq_err got=%b required=1", seq_err); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL repeat_illegal got=%b required=0", illegal); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL repeat_locked got=%b required=0", locked); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL repeat_err got=%0d required=1", err_count); end
  endtask

  task automatic test_err_sat();
    logic [1:0] exp_e2 [0:4] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 1'b1);
      step(4'b0001, 1'b1);
      step(4'b0011, 1'b1);
      step(4'b0111, 1'b1);
      checks++; if (e2_locked !== 1'b1) begin failures++; $display("FAIL sat_lock i=%0d got=%b required=1", i, e2_locked); end
      step(4'b0101, 1'b1);
      checks++; if (e2_err !== exp_e2[i]) begin failures++; $display("FAIL sat_err2 i=%0d got=%0d required=%0d", i, e2_err, exp_e2[i]); end
      checks++; if (err_count !== 8'(i + 1)) begin failures++; $display("FAIL sat_err8 i=%0d got=%0d required=%0d", i, err_count, i + 1); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k <= 56; k++) step(seq[k % 8], 1'b1);
    checks++; if (rev_count !== 8'd7 || locked !== 1'b1) begin failures++; $display("FAIL mid_pre rev=%0d locked=%b required rev=7 locked=1", rev_count, locked); end
    @(negedge clock);
    reset    = 1'b1;
    jc_valid = 1'b1;
    jc_in    = 4'b0001;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++; if ({phase_onehot, phase_idx, illegal, seq_err, locked} !== 14'd0) begin
      failures++; $display("FAIL mid_reset_outs onehot=%h idx=%0d ill=%b se=%b lk=%b required all 0", phase_onehot, phase_idx, illegal, seq_err, locked); end
    checks++; if ({rev_count, err_count} !== 16'd0) begin failures++; $display("FAIL mid_reset_counts rev=%0d err=%0d required 0", rev_count, err_count); end
    step(4'b0001, 1'b1);
    checks++; if (phase_idx !== 3'd1) begin failures++; $display("FAIL mid_post_idx got=%0d required=1", phase_idx); end
    checks++; if (phase_onehot !== 8'h02) begin failures++; $display("FAIL mid_post_onehot got=%h required=02", phase_onehot); end
    checks++; if ({locked, seq_err, illegal} !== 3'b000) begin failures++; $display("FAIL mid_post_flags got=%b%b%b required=000", locked, seq_err, illegal); end
  endtask

  initial begin
    test_reset();
    test_count_lock();
    test_illegal();
    test_skip();
    test_hold();
    test_repeat();
    test_err_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
